// File: rtl/ela_pkg.sv
// Shared constants and types for the ELA frame-buffer arbiter slice.
package ela_pkg;

    localparam int unsigned IMG_W       = 32;
    localparam int unsigned IMG_H       = 31;
    localparam int unsigned FRAME_WORDS = IMG_W * IMG_H;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ela_mem_arbiter_if.sv
// Requester, grant, read-return and memory-side signals of the frame-buffer arbiter.
interface ela_mem_arbiter_if #(
    parameter int unsigned AW = ela_pkg::AW,
    parameter int unsigned DW = ela_pkg::DW
);

    logic          req0;
    logic          lock0;
    logic          wen0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic [DW-1:0] rdata0;
    logic          rvalid0;

    logic          req1;
    logic          lock1;
    logic          wen1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic [DW-1:0] rdata1;
    logic          rvalid1;

    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, lock0, wen0, addr0, wdata0,
        input  req1, lock1, wen1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rdata0, rvalid0,
        output gnt1, rdata1, rvalid1,
        output mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req0, lock0, wen0, addr0, wdata0,
        output req1, lock1, wen1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rdata0, rvalid0,
        input  gnt1, rdata1, rvalid1,
        input  mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ela_rd_return.sv
// Tags each read access and routes the 1-cycle-latency memory data back to its issuer.
module ela_rd_return #(
    parameter int unsigned DW = ela_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en_i,
    input  logic          rd_tag_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o
);

    logic vld_q;
    logic tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            tag_q <= 1'b0;
        end else begin
            vld_q <= rd_en_i;
            if (rd_en_i) begin
                tag_q <= rd_tag_i;
            end
        end
    end

    assign rvalid0_o = vld_q & ~tag_q;
    assign rvalid1_o = vld_q &  tag_q;
    assign rdata0_o  = mem_rdata_i;
    assign rdata1_o  = mem_rdata_i;

endmodule

// File: rtl/ela_mem_arbiter.sv
// Burst round-robin arbiter between the ELA engine (0) and the host readout port (1)
// for the single-port frame buffer.
module ela_mem_arbiter
    import ela_pkg::*;
#(
    parameter int unsigned MAX_BURST = 32,
    parameter int unsigned AW        = ela_pkg::AW,
    parameter int unsigned DW        = ela_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    ela_mem_arbiter_if.slave  bus
);

    localparam int unsigned    CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0]  SAT  = CW'(MAX_BURST);

    arb_state_e    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic gnt0, gnt1;
    logic acc0, acc1;
    logic last_acc;
    logic rd_en;

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign acc0 = gnt0 & bus.req0;
    assign acc1 = gnt1 & bus.req1;
    // cnt_q counts accesses before this cycle, so this one is the MAX_BURST-th or later
    assign last_acc = (cnt_q >= LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = ptr_q ? OWN1 : OWN0;
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0 || (last_acc && bus.req1 && !bus.lock0)) begin
                    state_d = bus.req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!bus.req1 || (last_acc && bus.req0 && !bus.lock1)) begin
                    state_d = bus.req0 ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt0      = gnt0;
        bus.gnt1      = gnt1;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        if (acc0) begin
            bus.mem_wen   = bus.wen0;
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
        end else if (acc1) begin
            bus.mem_wen   = bus.wen1;
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((acc0 || acc1) && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            if (acc0 || acc1) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
            end
        end
    end

    assign rd_en = (acc0 & ~bus.wen0) | (acc1 & ~bus.wen1);

    ela_rd_return #(
        .DW (DW)
    ) u_rd_return (
        .clk         (clk),
        .rst         (rst),
        .rd_en_i     (rd_en),
        .rd_tag_i    (acc1),
        .mem_rdata_i (bus.mem_rdata),
        .rdata0_o    (bus.rdata0),
        .rdata1_o    (bus.rdata1),
        .rvalid0_o   (bus.rvalid0),
        .rvalid1_o   (bus.rvalid1)
    );

endmodule

// File: tb/tb_ela_mem_arbiter.sv
// Directed self-checking bench for ela_mem_arbiter with a 1-cycle-latency memory model.
module tb_ela_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    mem [1024];
    logic [1023:0] wr_q = '0;

    ela_mem_arbiter_if bus ();

    ela_mem_arbiter #(
        .MAX_BURST (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [9:0] a);
        if (a == 10'd100) return 8'h5A;
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wen) begin
            mem[bus.mem_addr]  <= bus.mem_wdata;
            wr_q[bus.mem_addr] <= 1'b1;
        end
        bus.mem_rdata <= wr_q[bus.mem_addr] ? mem[bus.mem_addr] : pat(bus.mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.lock0 = 1'b0; bus.wen0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.lock1 = 1'b0; bus.wen1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Requester 0 streams 40 reads from base; requester 1 asks from cycle 5 for 4 writes.
    task automatic run_stream(input logic lk, input int unsigned base,
                              output int first_g1, output int resume_addr,
                              output logic g1_rv0, output logic [7:0] g1_rd0, output logic g1_rv1);
        int n0 = 0;
        int n1 = 0;
        logic prev_rd = 1'b0;
        logic [9:0] prev_a = '0;
        logic acc0, acc1;
        logic seen_g1 = 1'b0;
        logic resumed = 1'b0;
        first_g1 = -1; resume_addr = -1;
        g1_rv0 = 1'b0; g1_rd0 = '0; g1_rv1 = 1'b0;
        for (int c = 0; c < 150 && !(n0 == 40 && n1 == 4); c++) begin
            bus.req0  = (n0 < 40);
            bus.lock0 = lk;
            bus.wen0  = 1'b0;
            bus.addr0 = 10'(base + 32'(n0));
            bus.req1  = (c >= 5) && (n1 < 4);
            bus.wen1  = 1'b1;
            bus.addr1 = 10'(500 + n1);
            bus.wdata1 = 8'(n1);
            @(negedge clk);
            acc0 = bus.gnt0 && bus.req0;
            acc1 = bus.gnt1 && bus.req1;
            chk("rvalid0", 32'(bus.rvalid0), 32'(prev_rd));
            if (prev_rd) chk("rdata0", 32'(bus.rdata0), 32'(pat(prev_a)));
            chk("rvalid1_idle", 32'(bus.rvalid1), 32'd0);
            if (acc0) chk("addr0_seq", 32'(bus.mem_addr), base + 32'(n0));
            if (bus.gnt1 && !seen_g1) begin
                seen_g1  = 1'b1;
                first_g1 = c;
                g1_rv0   = bus.rvalid0;
                g1_rd0   = bus.rdata0;
                g1_rv1   = bus.rvalid1;
            end
            if (acc0 && seen_g1 && !resumed) begin
                resumed     = 1'b1;
                resume_addr = int'(bus.mem_addr);
            end
            prev_rd = acc0;
            prev_a  = bus.addr0;
            tick();
            if (acc0) n0++;
            if (acc1) n1++;
        end
        chk("stream_n0", 32'(n0), 32'd40);
        chk("stream_n1", 32'(n1), 32'd4);
        idle_inputs();
        repeat (2) tick();
    endtask

    initial begin
        int fg1, ra;
        logic rv0, rv1;
        logic [7:0] rd0;

        idle_inputs();
        reset_dut();

        // Reset state
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);

        // Requester 0 alone: 32 writes to 0..31
        bus.req0 = 1'b1; bus.wen0 = 1'b1; bus.addr0 = '0; bus.wdata0 = 8'h10;
        @(negedge clk);
        chk("t1_latency", 32'(bus.gnt0), 32'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            bus.addr0  = 10'(i);
            bus.wdata0 = 8'(8'h10 + i);
            @(negedge clk);
            chk("t1_gnt0", 32'(bus.gnt0), 32'd1);
            chk("t1_wen", 32'(bus.mem_wen), 32'd1);
            chk("t1_addr", 32'(bus.mem_addr), 32'(i));
            chk("t1_gnt1", 32'(bus.gnt1), 32'd0);
            tick();
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("t1_no_wen", 32'(bus.mem_wen), 32'd0);
        chk("t1_addr_hold", 32'(bus.mem_addr), 32'd31);
        chk("t1_wdata_hold", 32'(bus.mem_wdata), 32'h2F);
        tick();
        @(negedge clk);
        chk("t1_release", 32'(bus.gnt0), 32'd0);
        // Requester 0 was granted last, so requester 1 wins this conflict
        tick();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        @(negedge clk);
        chk("t1_rr_gnt1", 32'(bus.gnt1), 32'd1);
        chk("t1_rr_gnt0", 32'(bus.gnt0), 32'd0);
        idle_inputs();
        repeat (2) tick();

        // Simultaneous requests from reset, then handover without idle bubble
        reset_dut();
        bus.req0 = 1'b1; bus.wen0 = 1'b1; bus.addr0 = 10'd200; bus.wdata0 = 8'h11;
        bus.req1 = 1'b1; bus.wen1 = 1'b1; bus.addr1 = 10'd300; bus.wdata1 = 8'h22;
        @(negedge clk);
        chk("t2_idle", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        tick();
        @(negedge clk);
        chk("t2_first_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t2_first_gnt1", 32'(bus.gnt1), 32'd0);
        repeat (2) tick();
        bus.req0 = 1'b0;
        tick();
        @(negedge clk);
        chk("t2_handover_gnt1", 32'(bus.gnt1), 32'd1);
        chk("t2_handover_gnt0", 32'(bus.gnt0), 32'd0);
        chk("t2_handover_addr", 32'(bus.mem_addr), 32'd300);
        idle_inputs();
        repeat (3) tick();

        // Unlocked stream: pre-empted after access 32, resumes at 64
        reset_dut();
        run_stream(1'b0, 32, fg1, ra, rv0, rd0, rv1);
        chk("t3_first_gnt1_cycle", 32'(fg1), 32'd33);
        chk("t3_resume_addr", 32'(ra), 32'd64);

        // Locked stream: all 40 accesses finish first
        reset_dut();
        run_stream(1'b1, 32, fg1, ra, rv0, rd0, rv1);
        chk("t4_first_gnt1_cycle", 32'(fg1), 32'd42);
        chk("t4_no_resume", 32'(ra), 32'hFFFF_FFFF);

        // Read of addr 100 as the last access before handover
        reset_dut();
        run_stream(1'b0, 69, fg1, ra, rv0, rd0, rv1);
        chk("t5_first_gnt1_cycle", 32'(fg1), 32'd33);
        chk("t5_rvalid0", 32'(rv0), 32'd1);
        chk("t5_rdata0", 32'(rd0), 32'h5A);
        chk("t5_rvalid1", 32'(rv1), 32'd0);

        // Reset mid-burst at access 10 (write) with a read return pending from access 9
        reset_dut();
        bus.req0 = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            bus.wen0   = ((k % 2) == 0);
            bus.addr0  = 10'(k);
            bus.wdata0 = 8'(k);
            if (k < 10) tick();
        end
        #1;
        chk("t6_pre_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t6_pre_wen", 32'(bus.mem_wen), 32'd1);
        chk("t6_pre_rvalid0", 32'(bus.rvalid0), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("t6_rst_wen", 32'(bus.mem_wen), 32'd0);
        chk("t6_rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("t6_rst_addr", 32'(bus.mem_addr), 32'd0);
        tick();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.wen0 = 1'b0; bus.addr0 = 10'd5;
        bus.req1 = 1'b1; bus.wen1 = 1'b0; bus.addr1 = 10'd6;
        tick();
        @(negedge clk);
        chk("t6_after_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t6_after_gnt1", 32'(bus.gnt1), 32'd0);
        idle_inputs();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ela_mem_arbiter.md
Name: ela_mem_arbiter

Overview:
Two-requester arbiter for the single-port 1024x8 frame buffer used by the edge-based line-average (ELA) engine. Requester 0 is the ELA engine, which performs row writes and neighbour-pixel reads. Requester 1 is the host readout/DMA port, which drains finished rows. The block grants the port in bursts with round-robin fairness, muxes address, data and write-enable onto the memory, and routes 1-cycle-latency read data back to whichever requester issued the read.

Parameters:
MAX_BURST, 32, accesses allowed per grant while the other side waits and lock is low (one image row)
AW, 10, address width
DW, 8, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req0  in  1  requester 0 access request (one access per cycle while high and granted)
lock0  in  1  requester 0 burst lock; suppresses MAX_BURST pre-emption
wen0  in  1  requester 0 write enable (1 = write, 0 = read)
addr0  in  AW  requester 0 address
wdata0  in  DW  requester 0 write data
gnt0  out  1  requester 0 owns the port this cycle
rdata0  out  DW  read data to requester 0
rvalid0  out  1  rdata0 valid
req1, lock1, wen1, addr1, wdata1  in  as above  requester 1
gnt1, rdata1, rvalid1  out  as above  requester 1
mem_wen  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after the read address

Behaviour:
- Reset values:
  - State IDLE; gnt0 = gnt1 = 0; rvalid0 = rvalid1 = 0.
  - mem_wen = 0; mem_addr = 0; mem_wdata = 0.
  - Burst counter 0; round-robin pointer = 0 (requester 0 wins the first conflict).
- States: IDLE, OWN0, OWN1. gnt0 = (state == OWN0) and gnt1 = (state == OWN1), both decoded from registered state.
- Access definition: an access occurs in a cycle where gnt_x = 1 and req_x = 1. mem_wen = wen_x on that cycle; mem_addr and mem_wdata come from requester x, combinationally from the registered grant.
  - On non-access cycles mem_wen = 0, and mem_addr/mem_wdata hold their last value.
- IDLE transitions:
  - Only one requester asserting: go to that requester's OWN state.
  - Both asserting: go to OWN[pointer].
  - Neither: stay in IDLE.
  - Grant appears the cycle after req is first seen, so the minimum request-to-first-access latency is 1 cycle.
- OWNx release: the state is left at the clock edge when either condition holds:
  - (a) req_x = 0 this cycle; or
  - (b) burst_cnt reaches MAX_BURST on this access, req_y = 1, and lock_x = 0.
- OWNx next state:
  - If req_y = 1: go directly to OWNy, with no idle bubble.
  - Otherwise: go to IDLE.
- Pointer: set to y whenever x is granted, so the loser of the last grant wins the next conflict.
- Burst counter:
  - Cleared on every grant change.
  - Increments per access.
  - Saturates at MAX_BURST while lock_x = 1, or while req_y = 0 (the owner keeps streaming uncontested).
- Pre-empted requester: sees gnt drop and must hold req, addr, wen and wdata stable until regranted. Accesses are never dropped.
- Read return:
  - A read access (wen_x = 0) registers a tag = x and a valid flag.
  - Next cycle: rvalid_x = 1 for exactly one cycle, and rdata_x = mem_rdata.
  - Correct even if the grant switched in between; back-to-back reads give a continuous rvalid stream.
  - rdata of the non-tagged requester is don't-care (drive mem_rdata to both).
- Simultaneous events: req_x falling while req_y rises in the same cycle means handover next cycle. Both requests rising from IDLE in the same cycle are resolved by the pointer.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values; a pending rvalid is discarded.

Decomposition:
- Package ela_pkg:
  - Frame constants: IMG_W = 32, IMG_H = 31, FRAME_WORDS = 992.
  - AW and DW.
  - Arbiter state enum {IDLE, OWN0, OWN1}.
- One sub-module, ela_rd_return: the tag/valid register and the rdata/rvalid routing.

Test Plan:
- Only req0, 32 writes to addr 0..31 → gnt0 from cycle 1; mem_wen high for 32 cycles with mem_addr 0..31; gnt1 stays 0.
- req0 and req1 rise together from reset → gnt0 first. After req0 drops, gnt1 rises the next cycle with no IDLE cycle. The next conflict goes to requester 1.
- req0 streams 40 reads at addr 32.., lock0 = 0, req1 high from cycle 5 → handover after access 32. Requester 1 is served; requester 0 resumes at addr 64 with no lost access.
- Same as above with lock0 = 1 → all 40 accesses of requester 0 complete before gnt1 asserts.
- Requester 0 reads addr 100 (mem holds 0x5A) in the cycle before a handover to requester 1 → rvalid0 = 1 and rdata0 = 0x5A one cycle later, while gnt1 = 1; rvalid1 stays 0.
- rst asserted mid-burst at access 10 → same cycle gnt0 = 0, mem_wen = 0, rvalid = 0. After release, the first conflict is won by requester 0.
